// File: rtl/im_port_arbiter_if.sv
// Shared bus bundle between the instruction-memory port arbiter, its two
// requesters (fetch, loader) and the single-ported instruction RAM.
interface im_port_arbiter_if #(
  parameter int IDX_W = 11
);
  // Fetch side
  logic             f_req;
  logic [31:0]      f_addr;
  logic             f_gnt;
  logic             f_rvalid;
  logic [31:0]      f_rdata;
  logic             f_fault;
  // Loader side
  logic             l_req;
  logic             l_we;
  logic [31:0]      l_addr;
  logic [31:0]      l_wdata;
  logic             l_lock;
  logic             l_gnt;
  logic             l_rvalid;
  logic [31:0]      l_rdata;
  logic             l_fault;
  // RAM side
  logic             mem_en;
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  // Arbiter view
  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, f_fault,
    output l_gnt, l_rvalid, l_rdata, l_fault,
    output mem_en, mem_we, mem_idx, mem_wdata
  );

  // Requester / RAM-model view
  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_fault,
    input  l_gnt, l_rvalid, l_rdata, l_fault,
    input  mem_en, mem_we, mem_idx, mem_wdata
  );
endinterface

// File: rtl/im_port_arbiter.sv
// Shares one synchronous single-ported instruction RAM between the fetch
// stage and the program loader: byte-address to word-index translation,
// range/alignment fault detection, fixed-priority arbitration with a loader
// starvation override, and one-cycle response sequencing.
module im_port_arbiter #(
  parameter logic [31:0] BASE_ADDR    = 32'h00003000,
  parameter int          IDX_W        = 11,
  parameter int          STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              reset_n,
  im_port_arbiter_if.slave bus
);
  localparam int          SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  // Size of the code segment in bytes; offsets at or above this fault.
  localparam logic [31:0] SPAN       = 32'd1 << (IDX_W + 2);
  localparam logic [1:0]  OWN_NONE   = 2'd0;
  localparam logic [1:0]  OWN_FETCH  = 2'd1;
  localparam logic [1:0]  OWN_LOAD   = 2'd2;

  logic [31:0]   f_off, l_off;
  logic          f_bad, l_bad;
  logic          starve_hit;
  logic          f_gnt_c, l_gnt_c;
  logic [SW-1:0] starve_d, starve_q;
  logic [1:0]    owner_d, owner_q;
  logic          fault_d, fault_q;
  logic          write_d, write_q;
  logic          f_own, l_own;

  // Offsets are modular, so addresses below the base wrap high and fault.
  always_comb begin
    f_off = bus.f_addr - BASE_ADDR;
    l_off = bus.l_addr - BASE_ADDR;
    f_bad = (bus.f_addr[1:0] != 2'b00) || (f_off >= SPAN);
    l_bad = (bus.l_addr[1:0] != 2'b00) || (l_off >= SPAN);
  end

  // Grant decision; gated by reset so outputs are quiet while reset is held.
  always_comb begin
    starve_hit = (starve_q == STARVE_MAX);
    l_gnt_c    = reset_n && bus.l_req && (bus.l_lock || !bus.f_req || starve_hit);
    f_gnt_c    = reset_n && bus.f_req && !bus.l_lock && !(bus.l_req && starve_hit);
  end

  // Saturating count of consecutive cycles the loader asked and was denied.
  always_comb begin
    starve_d = '0;
    if (bus.l_req && !l_gnt_c) begin
      starve_d = starve_hit ? starve_q : starve_q + 1'b1;
    end
  end

  // RAM drive: only a granted, non-faulting access touches the RAM.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_idx   = '0;
    bus.mem_wdata = '0;
    if (f_gnt_c && !f_bad) begin
      bus.mem_en    = 1'b1;
      bus.mem_idx   = f_off[IDX_W+1:2];
      bus.mem_wdata = bus.l_wdata;
    end else if (l_gnt_c && !l_bad) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.l_we;
      bus.mem_idx   = l_off[IDX_W+1:2];
      bus.mem_wdata = bus.l_wdata;
    end
  end

  // Next response-register contents: who owns next cycle's response and how.
  always_comb begin
    owner_d = OWN_NONE;
    if (f_gnt_c) begin
      owner_d = OWN_FETCH;
    end else if (l_gnt_c) begin
      owner_d = OWN_LOAD;
    end
    fault_d = (f_gnt_c && f_bad) || (l_gnt_c && l_bad);
    write_d = l_gnt_c && bus.l_we;
  end

  // Response and starvation state; reset drops any in-flight response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q  <= OWN_NONE;
      fault_q  <= 1'b0;
      write_q  <= 1'b0;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      fault_q  <= fault_d;
      write_q  <= write_d;
      starve_q <= starve_d;
    end
  end

  // Response steering; read data passes only for non-faulting reads.
  always_comb begin
    f_own        = (owner_q == OWN_FETCH);
    l_own        = (owner_q == OWN_LOAD);
    bus.f_gnt    = f_gnt_c;
    bus.l_gnt    = l_gnt_c;
    bus.f_rvalid = f_own;
    bus.l_rvalid = l_own;
    bus.f_fault  = f_own && fault_q;
    bus.l_fault  = l_own && fault_q;
    bus.f_rdata  = (f_own && !fault_q && !write_q) ? bus.mem_rdata : 32'h0;
    bus.l_rdata  = (l_own && !fault_q && !write_q) ? bus.mem_rdata : 32'h0;
  end
endmodule

// File: tb/tb_im_port_arbiter.sv
// Directed bench for im_port_arbiter with a behavioural single-port RAM
// preloaded so that word i holds 32'hA000_0000 + i.
module tb_im_port_arbiter;
  logic clk;
  logic reset_n;
  logic ram_init;
  int   pass_cnt;
  int   total_cnt;

  im_port_arbiter_if #(.IDX_W(11)) bus ();

  im_port_arbiter #(
    .BASE_ADDR(32'h00003000),
    .IDX_W(11),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: registered read, writes visible from the next cycle.
  logic [31:0] ram [0:2047];
  logic [31:0] ram_rdata;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 2048; i++) ram[i] <= 32'hA000_0000 + i;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_idx] <= bus.mem_wdata;
      else            ram_rdata <= ram[bus.mem_idx];
    end
  end
  assign bus.mem_rdata = ram_rdata;

  wire [114:0] all_out = {bus.f_gnt, bus.f_rvalid, bus.f_rdata, bus.f_fault,
                          bus.l_gnt, bus.l_rvalid, bus.l_rdata, bus.l_fault,
                          bus.mem_en, bus.mem_we, bus.mem_idx, bus.mem_wdata};

  task automatic test_reset();
    bus.f_req = 1'b1; bus.f_addr = 32'h00003000;
    #1;
    total_cnt++; if (all_out !== '0) $display("FAIL reset_idle: got %h expected 0", all_out); else pass_cnt++;
    @(posedge clk); #1;
    ram_init = 1'b0;
    total_cnt++; if (all_out !== '0) $display("FAIL reset_held: got %h expected 0", all_out); else pass_cnt++;
    reset_n = 1'b1;
    #1;
    total_cnt++; if ({bus.f_gnt, bus.mem_en, bus.mem_idx} !== {1'b1, 1'b1, 11'd0}) $display("FAIL grant_after_release: got %b expected 1_1_0", {bus.f_gnt, bus.mem_en, bus.mem_idx}); else pass_cnt++;
    // Reset asserted during the grant cycle: the grant vanishes immediately.
    reset_n = 1'b0;
    #1;
    total_cnt++; if (all_out !== '0) $display("FAIL reset_async_grant: got %h expected 0", all_out); else pass_cnt++;
    @(posedge clk); #1;
    bus.f_req = 1'b0;
    reset_n = 1'b1;
    #1;
    total_cnt++; if (bus.f_rvalid !== 1'b0) $display("FAIL no_stray_rvalid: got %b expected 0", bus.f_rvalid); else pass_cnt++;
    // Reset asserted while a read response is being presented.
    bus.f_req = 1'b1; bus.f_addr = 32'h00003000;
    @(posedge clk); #1;
    bus.f_req = 1'b0;
    total_cnt++; if (bus.f_rvalid !== 1'b1) $display("FAIL midread_rvalid: got %b expected 1", bus.f_rvalid); else pass_cnt++;
    reset_n = 1'b0;
    #1;
    total_cnt++; if (all_out !== '0) $display("FAIL reset_midread: got %h expected 0", all_out); else pass_cnt++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (bus.f_rvalid !== 1'b0) $display("FAIL no_rvalid_after_release: got %b expected 0", bus.f_rvalid); else pass_cnt++;
    $display("reset: sequence done");
  endtask

  task automatic test_fetch_reads();
    bus.f_req = 1'b1; bus.f_addr = 32'h00003000;
    #1;
    total_cnt++; if ({bus.f_gnt, bus.mem_en, bus.mem_we, bus.mem_idx} !== {1'b1, 1'b1, 1'b0, 11'd0}) $display("FAIL fetch0_drive: got %b expected 1_1_0_0", {bus.f_gnt, bus.mem_en, bus.mem_we, bus.mem_idx}); else pass_cnt++;
    $display("fetch read addr=%h idx=%h", bus.f_addr, bus.mem_idx);
    @(posedge clk); #1;
    total_cnt++; if ({bus.f_rvalid, bus.f_fault, bus.f_rdata} !== {1'b1, 1'b0, 32'hA000_0000}) $display("FAIL fetch0_resp: got %b_%b_%h expected 1_0_a0000000", bus.f_rvalid, bus.f_fault, bus.f_rdata); else pass_cnt++;
    bus.f_addr = 32'h00003004;
    #1;
    total_cnt++; if ({bus.f_gnt, bus.mem_en, bus.mem_idx} !== {1'b1, 1'b1, 11'd1}) $display("FAIL fetch1_drive: got %b expected 1_1_1", {bus.f_gnt, bus.mem_en, bus.mem_idx}); else pass_cnt++;
    $display("fetch read addr=%h idx=%h", bus.f_addr, bus.mem_idx);
    @(posedge clk); #1;
    total_cnt++; if ({bus.f_rvalid, bus.f_fault, bus.f_rdata} !== {1'b1, 1'b0, 32'hA000_0001}) $display("FAIL fetch1_resp: got %b_%b_%h expected 1_0_a0000001", bus.f_rvalid, bus.f_fault, bus.f_rdata); else pass_cnt++;
    bus.f_req = 1'b0;
    #1;
    total_cnt++; if ({bus.f_gnt, bus.mem_en} !== 2'b00) $display("FAIL fetch_idle_drive: got %b expected 00", {bus.f_gnt, bus.mem_en}); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (bus.f_rvalid !== 1'b0) $display("FAIL fetch_idle_rvalid: got %b expected 0", bus.f_rvalid); else pass_cnt++;
  endtask

  task automatic test_faults();
    logic [31:0] addrs [3];
    addrs[0] = 32'h00002FFC;
    addrs[1] = 32'h00005000;
    addrs[2] = 32'h00003002;
    for (int i = 0; i < 3; i++) begin
      bus.f_req = 1'b1; bus.f_addr = addrs[i];
      #1;
      total_cnt++; if ({bus.f_gnt, bus.mem_en} !== 2'b10) $display("FAIL fault%0d_drive: got %b expected 10", i, {bus.f_gnt, bus.mem_en}); else pass_cnt++;
      $display("fetch fault addr=%h", addrs[i]);
      @(posedge clk); #1;
      total_cnt++; if ({bus.f_rvalid, bus.f_fault, bus.f_rdata} !== {1'b1, 1'b1, 32'h0}) $display("FAIL fault%0d_resp: got %b_%b_%h expected 1_1_0", i, bus.f_rvalid, bus.f_fault, bus.f_rdata); else pass_cnt++;
    end
    bus.f_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lock_write_fetch();
    bus.f_req = 1'b1; bus.f_addr = 32'h00003004;
    #1;
    total_cnt++; if (bus.f_gnt !== 1'b1) $display("FAIL prelock_fgnt: got %b expected 1", bus.f_gnt); else pass_cnt++;
    @(posedge clk); #1;
    // Lock rises while the fetch response is pending.
    bus.l_lock = 1'b1; bus.l_req = 1'b1; bus.l_we = 1'b1;
    bus.l_addr = 32'h00003008; bus.l_wdata = 32'hDEADBEEF;
    bus.f_addr = 32'h00003008;
    #1;
    total_cnt++; if ({bus.f_rvalid, bus.f_rdata} !== {1'b1, 32'hA000_0001}) $display("FAIL lock_pending_fetch: got %b_%h expected 1_a0000001", bus.f_rvalid, bus.f_rdata); else pass_cnt++;
    total_cnt++; if ({bus.f_gnt, bus.l_gnt, bus.mem_en, bus.mem_we, bus.mem_idx, bus.mem_wdata} !== {1'b0, 1'b1, 1'b1, 1'b1, 11'd2, 32'hDEADBEEF}) $display("FAIL lock_write_drive: got %h expected 0_1_1_1_002_deadbeef", {bus.f_gnt, bus.l_gnt, bus.mem_en, bus.mem_we, bus.mem_idx, bus.mem_wdata}); else pass_cnt++;
    $display("loader write addr=%h data=%h", bus.l_addr, bus.l_wdata);
    @(posedge clk); #1;
    bus.l_req = 1'b0; bus.l_we = 1'b0;
    #1;
    total_cnt++; if ({bus.l_rvalid, bus.l_fault, bus.l_rdata, bus.f_gnt, bus.f_rvalid} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) $display("FAIL write_ack: got %b_%b_%h_%b_%b expected 1_0_0_0_0", bus.l_rvalid, bus.l_fault, bus.l_rdata, bus.f_gnt, bus.f_rvalid); else pass_cnt++;
    bus.l_lock = 1'b0;
    #1;
    total_cnt++; if ({bus.f_gnt, bus.mem_en, bus.mem_idx} !== {1'b1, 1'b1, 11'd2}) $display("FAIL unlock_fetch_drive: got %b expected 1_1_2", {bus.f_gnt, bus.mem_en, bus.mem_idx}); else pass_cnt++;
    $display("fetch read addr=%h idx=%h", bus.f_addr, bus.mem_idx);
    @(posedge clk); #1;
    total_cnt++; if ({bus.f_rvalid, bus.f_fault, bus.f_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) $display("FAIL write_then_read: got %b_%b_%h expected 1_0_deadbeef", bus.f_rvalid, bus.f_fault, bus.f_rdata); else pass_cnt++;
    bus.f_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_starvation();
    logic exp_l;
    logic prev_l;
    prev_l = 1'b0;
    bus.f_req = 1'b1; bus.f_addr = 32'h00003000;
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h00003010;
    for (int i = 0; i < 10; i++) begin
      exp_l = ((i % 5) == 4);
      #1;
      total_cnt++; if ({bus.f_gnt, bus.l_gnt} !== {~exp_l, exp_l}) $display("FAIL starve_grant%0d: got %b expected %b", i, {bus.f_gnt, bus.l_gnt}, {~exp_l, exp_l}); else pass_cnt++;
      if (i > 0) begin
        total_cnt++; if ({bus.f_rvalid, bus.l_rvalid} !== {~prev_l, prev_l}) $display("FAIL starve_resp%0d: got %b expected %b", i, {bus.f_rvalid, bus.l_rvalid}, {~prev_l, prev_l}); else pass_cnt++;
      end
      $display("contended cycle %0d grant=%s", i, exp_l ? "L" : "F");
      prev_l = exp_l;
      @(posedge clk); #1;
    end
    bus.f_req = 1'b0; bus.l_req = 1'b0;
    #1;
    total_cnt++; if ({bus.f_rvalid, bus.l_rvalid, bus.l_rdata} !== {1'b0, 1'b1, 32'hA000_0004}) $display("FAIL starve_loader_data: got %b_%b_%h expected 0_1_a0000004", bus.f_rvalid, bus.l_rvalid, bus.l_rdata); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_loader_bounds();
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h00004FFC;
    #1;
    total_cnt++; if ({bus.l_gnt, bus.mem_en, bus.mem_we, bus.mem_idx} !== {1'b1, 1'b1, 1'b0, 11'h7FF}) $display("FAIL last_word_drive: got %b expected 1_1_0_7ff", {bus.l_gnt, bus.mem_en, bus.mem_we, bus.mem_idx}); else pass_cnt++;
    $display("loader read addr=%h idx=%h", bus.l_addr, bus.mem_idx);
    @(posedge clk); #1;
    total_cnt++; if ({bus.l_rvalid, bus.l_fault, bus.l_rdata} !== {1'b1, 1'b0, 32'hA000_07FF}) $display("FAIL last_word_resp: got %b_%b_%h expected 1_0_a00007ff", bus.l_rvalid, bus.l_fault, bus.l_rdata); else pass_cnt++;
    bus.l_addr = 32'h00005000;
    #1;
    total_cnt++; if ({bus.l_gnt, bus.mem_en} !== 2'b10) $display("FAIL past_end_drive: got %b expected 10", {bus.l_gnt, bus.mem_en}); else pass_cnt++;
    $display("loader fault addr=%h", bus.l_addr);
    @(posedge clk); #1;
    total_cnt++; if ({bus.l_rvalid, bus.l_fault, bus.l_rdata, bus.f_rvalid} !== {1'b1, 1'b1, 32'h0, 1'b0}) $display("FAIL past_end_resp: got %b_%b_%h_%b expected 1_1_0_0", bus.l_rvalid, bus.l_fault, bus.l_rdata, bus.f_rvalid); else pass_cnt++;
    bus.l_req = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (bus.l_rvalid !== 1'b0) $display("FAIL loader_idle_rvalid: got %b expected 0", bus.l_rvalid); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset_n   = 1'b0;
    ram_init  = 1'b1;
    bus.f_req = 1'b0; bus.f_addr = 32'h0;
    bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = 32'h0;
    bus.l_wdata = 32'h0; bus.l_lock = 1'b0;
    #2;
    test_reset();
    test_fetch_reads();
    test_faults();
    test_lock_write_fetch();
    test_starvation();
    test_loader_bounds();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
